// File: rtl/dsp_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pipe_pkg
// Shared types and helpers for the DSP pipeline delay line.
//   DEF_WIDTH / DEF_LANES / DEF_DEPTH : default lane width, lane count, depth
//   lane_t                            : one lane word at the default width
//   clamp_lat(sel, depth)             : output tap, saturated at depth
// -----------------------------------------------------------------------------
package dsp_pipe_pkg;

    localparam int DEF_WIDTH = 18;
    localparam int DEF_LANES = 2;
    localparam int DEF_DEPTH = 4;

    typedef logic [DEF_WIDTH-1:0] lane_t;

    // Tap selects past the end of the chain saturate to the last stage.
    function automatic int unsigned clamp_lat(input int unsigned sel,
                                              input int unsigned depth);
        return (sel > depth) ? depth : sel;
    endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// -----------------------------------------------------------------------------
// dsp_pipe_stage
// One register stage of the delay line: LANES words of WIDTH bits plus a
// shared valid bit.
//   clk, rst      : clock, async active-high reset (clears data and valid)
//   ce            : advance enable
//   flush         : synchronous clear, takes priority over ce
//   d, d_valid    : previous stage (or chain input)
//   q, q_valid    : registered stage contents
// Data of an invalid entry is carried as-is; only flush/rst zero it.
// -----------------------------------------------------------------------------
module dsp_pipe_stage #(
    parameter int WIDTH = 18,
    parameter int LANES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ce,
    input  logic                        flush,
    input  logic [LANES-1:0][WIDTH-1:0] d,
    input  logic                        d_valid,
    output logic [LANES-1:0][WIDTH-1:0] q,
    output logic                        q_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (flush) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (ce) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/dsp_pipe_delay_line.sv
// -----------------------------------------------------------------------------
// dsp_pipe_delay_line
// Multi-lane delay line with a run-time selectable output tap.
//   clk, rst   : clock, async active-high reset
//   ce         : chain advances only when high
//   flush      : synchronous clear of all stages (wins over ce)
//   lat_sel    : output tap, 0 = combinational bypass, >DEPTH clamps to DEPTH
//   d, d_valid : input lanes (lane i at [i*WIDTH +: WIDTH]) and qualifier
//   q, q_valid : data/valid at the selected tap
//   occ        : valid entries in stages 1..tap (only with DSP_PIPE_OCC_EN)
// Build option: define DSP_PIPE_OCC_EN to add the occ port and its popcount.
// -----------------------------------------------------------------------------
module dsp_pipe_delay_line
    import dsp_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LAT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   flush,
    input  logic [LAT_W-1:0]       lat_sel,
    input  logic                   d_valid,
    input  logic [LANES*WIDTH-1:0] d,
    output logic [LANES*WIDTH-1:0] q,
    output logic                   q_valid
`ifdef DSP_PIPE_OCC_EN
    ,
    output logic [LAT_W-1:0]       occ
`endif
);

    // Index 0 is the live input, so tap 0 falls out of the same mux as the
    // registered taps and needs no special case.
    logic [LANES-1:0][WIDTH-1:0] data_pipe [DEPTH+1];
    logic [DEPTH:0]              vld_pipe;
    logic [LAT_W-1:0]            tap;

    assign data_pipe[0] = d;
    assign vld_pipe[0]  = d_valid;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        dsp_pipe_stage #(
            .WIDTH (WIDTH),
            .LANES (LANES)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .ce      (ce),
            .flush   (flush),
            .d       (data_pipe[k-1]),
            .d_valid (vld_pipe[k-1]),
            .q       (data_pipe[k]),
            .q_valid (vld_pipe[k])
        );
    end

    // Tap changes act immediately; stages beyond the tap keep their history.
    assign tap     = LAT_W'(clamp_lat(32'(lat_sel), 32'(DEPTH)));
    assign q       = data_pipe[tap];
    assign q_valid = vld_pipe[tap];

`ifdef DSP_PIPE_OCC_EN
    logic [LAT_W-1:0] occ_cnt;

    always_comb begin
        occ_cnt = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (LAT_W'(k) <= tap && vld_pipe[k])
                occ_cnt = occ_cnt + LAT_W'(1);
        end
    end

    assign occ = occ_cnt;
`endif

endmodule

// File: doc/dsp_pipe_delay_line.md
# dsp_pipe_delay_line

Parametrised multi-lane pipeline delay line for the DSP datapath. Generalises the single register/bypass pair: each lane passes through up to DEPTH register stages, and the output tap (0 = combinational bypass, 1..DEPTH = registered) is selected at run time. Per-stage valid tracking, a synchronous flush and an optional occupancy count let downstream multiply/accumulate stages follow bubbles and latency changes without external bookkeeping.

## Interface
- WIDTH, 18, bits per lane
- LANES, 2, parallel lanes sharing all control
- DEPTH, 4, maximum register stages (≥1)
- LAT_W, $clog2(DEPTH+1), width of latency select
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high; clears all stage data and valid bits
- ce  in  1  clock enable; the chain advances only when high
- flush  in  1  synchronous clear of all stages and valid bits (on a clock edge, regardless of ce)
- lat_sel  in  LAT_W  output tap select; values >DEPTH clamp to DEPTH
- d_valid  in  1  input qualifier
- d  in  LANES*WIDTH  input data, lane i at [i*WIDTH +: WIDTH]
- q  out  LANES*WIDTH  data at the selected tap
- q_valid  out  1  valid at the selected tap
- occ  out  LAT_W  valid entries in stages 1..tap (present only with DSP_PIPE_OCC_EN)

## Operation
- Stage k (1..DEPTH) holds per-lane data and a valid bit. On a rising edge with ce=1: stage 1 ← {d, d_valid}, stage k ← stage k-1.
- ce=0: all stages hold. flush=1: all data ← 0, all valid ← 0; flush wins over ce.
- Tap t = min(lat_sel, DEPTH). t=0: q = d, q_valid = d_valid (combinational). t≥1: q/q_valid = stage t.
- A lat_sel change takes effect combinationally in the same cycle. Stages are not cleared. Entries beyond the new tap stay in the chain and are not re-emitted. Increasing t exposes stages that already hold real history.
- Data of an invalid entry is carried unchanged. It is not zeroed; consumers qualify with q_valid.
- All lanes share ce, flush and valid. Lane data never mixes.

## Timing
- Reset (async assert, sync-safe release): all stage data 0, all valid 0. For t≥1: q=0, q_valid=0, occ=0. For t=0: q/q_valid follow d/d_valid.
- Latency from d to q: exactly t ce-qualified edges. For t=0 latency is 0 cycles.
- Back-to-back input with ce held high: one word per cycle, no bubbles inserted.
- flush and d_valid on the same edge: the flush wins. Stage 1 becomes invalid and the input word is dropped.
- rst mid-operation: contents are lost immediately. The first valid output after release appears t ce-edges after the first accepted valid input.
- occ is registered-consistent: it is derived combinationally from the current valid bits and t. Range is 0..t.

## Configuration
- DSP_PIPE_OCC_EN defined: the occ port exists and equals the popcount of the valid bits in stages 1..t (0 when t=0).
- DSP_PIPE_OCC_EN undefined: the occ port and its popcount logic are absent. All other behaviour is identical.

## Structure
- Shared package dsp_pipe_pkg:
  - typedef lane_t (logic [WIDTH-1:0] at default width)
  - function clamp_lat(sel, depth)
  - default WIDTH/DEPTH constants
- Sub-module dsp_pipe_stage:
  - one LANES-wide data register plus valid bit, with async rst, ce and flush.
  - Instantiated DEPTH times in a generate loop.
- Top level holds the tap mux, the clamp and the optional occupancy popcount.

## Test plan
- Reset then bypass: rst pulse, lat_sel=0, d=lane0 0x00011/lane1 0x00022, d_valid=1 -> q equals d in the same cycle, q_valid=1, no clock needed.
- Fixed latency: lat_sel=3, ce=1, stream 1,2,3,4,5 on lane0 -> value 1 appears with q_valid=1 exactly 3 edges later, then one word per cycle.
- Stall: lat_sel=2, ce=0 for 2 cycles mid-stream -> q/q_valid frozen during the stall; sequence resumes without loss or duplication.
- Flush priority: pipeline full of valids, assert flush with ce=1 and d_valid=1 for one edge -> all valid 0 next cycle, q_valid=0 and occ=0 (OCC build); the input word never appears.
- Clamp and latency switch: DEPTH=4, lat_sel=7 -> behaves as 4. Then switch to 1 mid-stream -> q shows stage 1 the same cycle; words in stages 2-4 are never emitted.
- Async reset mid-stream: assert rst between edges with 3 valids in flight -> q_valid drops immediately. After release, the first valid output appears t edges after the next valid input.
